// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide unit feeding HI/LO
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opb_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 ready_q;
    logic                 div_zero_q;

    // Operand decode at start: op[0]=1 selects the unsigned variants.
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    assign sign_a = ~op[0] & a[WIDTH-1];
    assign sign_b = ~op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? (~a + 1'b1) : a;
    assign mag_b  = sign_b ? (~b + 1'b1) : b;

    // Multiply step: conditional add of the multiplicand into the upper half, then shift right.
    logic [WIDTH:0]       mul_sum_d;
    logic [2*WIDTH-1:0]   mul_acc_d;

    assign mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and subtract if it fits.
    logic [WIDTH:0]       div_shift_d;
    logic [WIDTH:0]       div_diff_d;
    logic                 div_ge_d;
    logic [WIDTH:0]       div_rem_d;
    logic [2*WIDTH-1:0]   div_acc_d;

    assign div_shift_d = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign div_diff_d  = div_shift_d - {1'b0, opb_q};
    assign div_ge_d    = (div_shift_d >= {1'b0, opb_q});
    assign div_rem_d   = div_ge_d ? div_diff_d : div_shift_d;
    assign div_acc_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge_d};

    // Sign fix-up; a most-negative quotient simply wraps back to itself.
    logic [2*WIDTH-1:0]   prod_fix_d;
    logic [WIDTH-1:0]     quo_fix_d;
    logic [WIDTH-1:0]     rem_fix_d;

    assign prod_fix_d = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix_d  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix_d  = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_q      <= '0;
            opb_q      <= '0;
            rem_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (start && !flush) begin
                        is_div_q   <= op[1];
                        neg_res_q  <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
                        acc_q      <= {{WIDTH{1'b0}}, mag_a};
                        opb_q      <= mag_b;
                        rem_q      <= '0;
                        cnt_q      <= CW'(WIDTH);
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        if (op[1] && (b == '0)) begin
                            div_zero_q <= 1'b1;
                            ready_q    <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (is_div_q) begin
                            acc_q <= div_acc_d;
                            rem_q <= div_rem_d;
                        end else begin
                            acc_q <= mul_acc_d;
                        end
                        if (cnt_q == CW'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            hi_q <= rem_fix_d;
                            lo_q <= quo_fix_d;
                        end else begin
                            hi_q <= prod_fix_d[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix_d[WIDTH-1:0];
                        end
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign div_zero = div_zero_q;

endmodule
